// File: rtl/io_bus_master_pkg.sv
// Shared types and widths for the J1 I/O bus initiator.
// IO_BUS_MASTER_BURST_EN adds a per-command burst length field.
package io_bus_master_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;
`ifdef IO_BUS_MASTER_BURST_EN
  localparam int unsigned LEN_W  = 4;
`endif

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
`ifdef IO_BUS_MASTER_BURST_EN
    logic [LEN_W-1:0]  len;
`endif
  } cmd_t;

endpackage

// File: rtl/if_io.sv
// J1 I/O bus: single-word strobed cycles, din is an OR-bus driven by the slaves.
interface if_io (
  input logic clk
);
  logic        rd;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] dout;
  logic [15:0] din;

  modport master (input clk, input din, output rd, output wr, output addr, output dout);
  modport slave  (input clk, input rd, input wr, input addr, input dout, output din);
endinterface

// File: rtl/io_cmd_fifo.sv
// Synchronous command FIFO; head entry is visible on pop_data without a pop.
module io_cmd_fifo
  import io_bus_master_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  cmd_t                   push_data,
  input  logic                   pop,
  output cmd_t                   pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);

endmodule

// File: rtl/io_bus_master.sv
// J1 I/O bus initiator: queues read/write commands and runs single-word bus cycles.
// Define IO_BUS_MASTER_BURST_EN to add cmd_len and expand each command into a burst.
module io_bus_master
  import io_bus_master_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned RD_WAIT = 0
) (
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
`ifdef IO_BUS_MASTER_BURST_EN
  input  logic [LEN_W-1:0]  cmd_len,
`endif
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  if_io.master              io
);
  localparam int unsigned CW     = $clog2(DEPTH) + 1;
  localparam int unsigned WAIT_W = 3;

  state_t            state;
  cmd_t              cmd_in;
  cmd_t              head;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;
  logic [WAIT_W-1:0] wait_cnt;
  logic              issue;
  logic              issue_write;
  logic [ADDR_W-1:0] issue_addr;
  logic [DATA_W-1:0] issue_wdata;
`ifdef IO_BUS_MASTER_BURST_EN
  logic [LEN_W-1:0]  beats_left;
  logic              cur_write;
  logic [DATA_W-1:0] cur_wdata;
`endif

  assign cmd_in.write = cmd_write;
  assign cmd_in.addr  = cmd_addr;
  assign cmd_in.wdata = cmd_wdata;
`ifdef IO_BUS_MASTER_BURST_EN
  assign cmd_in.len   = cmd_len;
`endif

  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;

  io_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (io.clk),
    .reset    (reset),
    .push     (push),
    .push_data(cmd_in),
    .pop      (pop),
    .pop_data (head),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

`ifdef IO_BUS_MASTER_BURST_EN
  assign busy = (count != '0) || (state != IDLE) || (beats_left != '0);
`else
  assign busy = (count != '0) || (state != IDLE);
`endif

  // Pick the next beat in IDLE: remaining burst beats take priority over the FIFO head.
  always_comb begin
    pop         = 1'b0;
    issue       = 1'b0;
    issue_write = head.write;
    issue_addr  = head.addr;
    issue_wdata = head.wdata;
    if (state == IDLE) begin
`ifdef IO_BUS_MASTER_BURST_EN
      if (beats_left != '0) begin
        issue       = 1'b1;
        issue_write = cur_write;
        issue_addr  = io.addr + ADDR_W'(1);
        issue_wdata = cur_wdata;
      end else
`endif
      if (!empty) begin
        issue = 1'b1;
        pop   = 1'b1;
      end
    end
  end

  always_ff @(posedge io.clk) begin
    if (reset) begin
      state     <= IDLE;
      io.rd     <= 1'b0;
      io.wr     <= 1'b0;
      io.addr   <= '0;
      io.dout   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      wait_cnt  <= '0;
`ifdef IO_BUS_MASTER_BURST_EN
      beats_left <= '0;
      cur_write  <= 1'b0;
      cur_wdata  <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (issue) begin
            io.addr <= issue_addr;
            if (issue_write) begin
              io.dout <= issue_wdata;
              io.wr   <= 1'b1;
              state   <= WRITE;
            end else begin
              io.rd    <= 1'b1;
              wait_cnt <= WAIT_W'(RD_WAIT);
              state    <= READ;
            end
`ifdef IO_BUS_MASTER_BURST_EN
            if (pop) begin
              beats_left <= head.len;
              cur_write  <= head.write;
              cur_wdata  <= head.wdata;
            end else begin
              beats_left <= beats_left - LEN_W'(1);
            end
`endif
          end
        end
        WRITE: begin
          io.wr <= 1'b0;
          state <= IDLE;
        end
        READ: begin
          if (wait_cnt == '0) begin
            rsp_rdata <= io.din;
            io.rd     <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end
        end
        RESP: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_master.sv
// Scoreboard bench for io_bus_master with a small peripheral slave on the J1 I/O bus.
module tb_io_bus_master;

  localparam int unsigned RDW = 3;
  localparam logic [15:0] LEDR = 16'h0100;
  localparam logic [15:0] LEDG = 16'h0101;
  localparam logic [15:0] HEX0 = 16'h0102;
  localparam logic [15:0] KEY  = 16'h0106;
  localparam logic [15:0] SW   = 16'h0107;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;
  logic        busy;
`ifdef IO_BUS_MASTER_BURST_EN
  logic [3:0]  cmd_len;
  assign cmd_len = 4'd0;
`endif

  logic [15:0] sreg [6];
  logic [9:0]  sw;
  logic [3:0]  key;
  logic [15:0] model_mem [6];
  logic [15:0] exp_rd [$];
  logic [31:0] exp_wr [$];
  int          checks = 0;
  int          errors = 0;
  int          wr_count = 0;
  int          rsp_count = 0;
  int          rdy_mode = 0;

  if_io io_if (.clk(clk));

  io_bus_master #(.DEPTH(4), .RD_WAIT(RDW)) dut (
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
`ifdef IO_BUS_MASTER_BURST_EN
    .cmd_len  (cmd_len),
`endif
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .busy     (busy),
    .io       (io_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endfunction

  function automatic logic in_map(input logic [15:0] a);
    return a[15:3] == 13'h0020;
  endfunction

  // Peripheral behaviour: LEDR 10 bits, LEDG 8 bits, HEX digits active-low 7 segments.
  function automatic logic [15:0] xf(input logic [2:0] idx, input logic [15:0] d);
    case (idx)
      3'd0:    return {6'h0, d[9:0]};
      3'd1:    return {8'h0, d[7:0]};
      3'd6,
      3'd7:    return 16'h0;
      default: return {9'h0, ~d[6:0]};
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 6; i++) sreg[i] <= 16'h0;
    end else if (io_if.wr && in_map(io_if.addr) && io_if.addr[2:0] < 3'd6) begin
      sreg[io_if.addr[2:0]] <= xf(io_if.addr[2:0], io_if.dout);
    end
  end

  always_comb begin
    io_if.din = 16'h0;
    if (io_if.rd && in_map(io_if.addr)) begin
      case (io_if.addr[2:0])
        3'd6:    io_if.din = {12'h0, key};
        3'd7:    io_if.din = {6'h0, sw};
        default: io_if.din = sreg[io_if.addr[2:0]];
      endcase
    end
  end

  function automatic logic [15:0] model_read(input logic [15:0] a);
    if (!in_map(a)) return 16'h0;
    case (a[2:0])
      3'd6:    return {12'h0, key};
      3'd7:    return {6'h0, sw};
      default: return model_mem[a[2:0]];
    endcase
  endfunction

  function automatic void model_push(input logic w, input logic [15:0] a, input logic [15:0] d);
    if (w) begin
      exp_wr.push_back({a, d});
      if (in_map(a) && a[2:0] < 3'd6) model_mem[a[2:0]] = xf(a[2:0], d);
    end else begin
      exp_rd.push_back(model_read(a));
    end
  endfunction

  function automatic void model_clear();
    exp_rd.delete();
    exp_wr.delete();
    for (int i = 0; i < 6; i++) model_mem[i] = 16'h0;
  endfunction

  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = 1'b0;
        default: rsp_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Bus and response monitor.
  logic        prev_wr = 1'b0;
  logic        prev_hold = 1'b0;
  logic [15:0] hold_data = 16'h0;
  logic [15:0] rd_addr = 16'h0;
  int          rd_len = 0;

  always @(negedge clk) begin
    if (reset) begin
      rd_len    = 0;
      prev_wr   = 1'b0;
      prev_hold = 1'b0;
    end else begin
      if (io_if.rd || io_if.wr) check("rd_wr_overlap", 32'(io_if.rd && io_if.wr), 32'd0);
      if (io_if.wr) begin
        wr_count++;
        check("wr_single_cycle", 32'(prev_wr), 32'd0);
        check("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
        if (exp_wr.size() != 0) begin
          logic [31:0] e;
          e = exp_wr.pop_front();
          check("wr_addr", 32'(io_if.addr), 32'(e[31:16]));
          check("wr_data", 32'(io_if.dout), 32'(e[15:0]));
        end
      end
      prev_wr = io_if.wr;
      if (io_if.rd) begin
        if (rd_len > 0) check("rd_addr_stable", 32'(io_if.addr), 32'(rd_addr));
        rd_addr = io_if.addr;
        rd_len++;
      end else if (rd_len > 0) begin
        check("rd_length", 32'(rd_len), 32'(RDW + 1));
        rd_len = 0;
      end
      if (rsp_valid) begin
        if (prev_hold) check("rsp_stable", 32'(rsp_rdata), 32'(hold_data));
        if (rsp_ready) begin
          rsp_count++;
          check("rsp_expected", 32'(exp_rd.size() != 0), 32'd1);
          if (exp_rd.size() != 0) check("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd.pop_front()));
        end
        prev_hold = !rsp_ready;
        hold_data = rsp_rdata;
      end else begin
        prev_hold = 1'b0;
      end
    end
  end

  task automatic send(input logic w, input logic [15:0] a, input logic [15:0] d);
    logic ok;
    ok = 1'b0;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = cmd_ready;
    end
    if (ok) begin
      @(posedge clk);
      model_push(w, a, d);
    end else begin
      check("cmd_accept_timeout", 32'd0, 32'd1);
    end
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      done = !busy && !rsp_valid && exp_rd.size() == 0 && exp_wr.size() == 0;
    end
    if (!done) check("idle_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic read_latency(input logic [15:0] a, input logic [15:0] d);
    int k;
    k = 0;
    send(1'b0, a, 16'h0);
    for (int i = 0; i < 50 && !rsp_valid; i++) begin
      @(negedge clk);
      k++;
    end
    check("rd_latency", 32'(k), 32'(RDW + 3));
    check("rd_value", 32'(rsp_rdata), 32'(d));
    wait_idle();
  endtask

  initial begin
    int wc;
    int rc;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 16'h0;
    cmd_wdata = 16'h0;
    sw        = 10'h2C3;
    key       = 4'h9;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd", 32'(io_if.rd), 32'd0);
    check("rst_wr", 32'(io_if.wr), 32'd0);
    check("rst_addr", 32'(io_if.addr), 32'd0);
    check("rst_dout", 32'(io_if.dout), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;

    // Single write to LEDG: strobe one cycle after the push, busy gone one cycle later.
    send(1'b1, LEDG, 16'h00A5);
    @(negedge clk);
    check("w_busy_queued", 32'(busy), 32'd1);
    check("w_no_early_wr", 32'(io_if.wr), 32'd0);
    @(negedge clk);
    check("w_strobe", 32'(io_if.wr), 32'd1);
    check("w_addr", 32'(io_if.addr), 32'(LEDG));
    check("w_dout", 32'(io_if.dout), 32'h00A5);
    check("w_busy_strobe", 32'(busy), 32'd1);
    @(negedge clk);
    check("w_strobe_end", 32'(io_if.wr), 32'd0);
    check("w_busy_drop", 32'(busy), 32'd0);
    check("w_dout_hold", 32'(io_if.dout), 32'h00A5);
    check("w_ledg", 32'(sreg[1]), 32'h00A5);
    wait_idle();

    read_latency(SW, 16'h02C3);
    read_latency(KEY, 16'h0009);

    // Stalled response while the FIFO fills with writes.
    rdy_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    send(1'b0, SW, 16'h0);
    for (int i = 0; i < 50 && !rsp_valid; i++) @(negedge clk);
    check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
    @(posedge clk);
    #1;
    wc = wr_count;
    send(1'b1, LEDR, 16'h0155);
    send(1'b1, LEDG, 16'h003C);
    send(1'b1, HEX0, 16'h0040);
    send(1'b1, HEX0 + 16'd1, 16'h0079);
    cmd_write = 1'b1;
    cmd_addr  = LEDR;
    cmd_wdata = 16'h0077;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("full_cmd_ready", 32'(cmd_ready), 32'd0);
      check("full_no_wr", 32'(wr_count), 32'(wc));
    end
    cmd_valid = 1'b0;
    rdy_mode = 0;
    wait_idle();
    check("full_wr_count", 32'(wr_count - wc), 32'd4);
    check("full_hex0", 32'(sreg[2]), 32'h003F);

    // Reset while a read is on the bus with two commands queued.
    send(1'b0, SW, 16'h0);
    send(1'b0, KEY, 16'h0);
    send(1'b0, LEDG, 16'h0);
    @(negedge clk);
    check("pre_rst_rd", 32'(io_if.rd), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    model_clear();
    rc = rsp_count;
    @(negedge clk);
    check("mid_rst_rd", 32'(io_if.rd), 32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("mid_rst_no_rsp", 32'(rsp_count), 32'(rc));
    check("mid_rst_no_bus", 32'(io_if.rd || io_if.wr), 32'd0);
    @(posedge clk);
    #1;

    // Random traffic with a randomly stalling consumer.
    rdy_mode = 2;
    for (int n = 0; n < 200; n++) begin
      int idx;
      logic [15:0] a;
      idx = $urandom_range(0, 8);
      a = (idx == 8) ? 16'h0200 : LEDR + 16'(idx);
      send(1'($urandom_range(0, 1)), a, 16'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rdy_mode = 0;
    wait_idle();
    for (int i = 0; i < 6; i++) check("final_slave_state", 32'(sreg[i]), 32'(model_mem[i]));
    check("final_rd_queue", 32'(exp_rd.size()), 32'd0);
    check("final_wr_queue", 32'(exp_wr.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_bus_master.md
Name: io_bus_master

Overview:
- Initiator side of the J1 I/O bus.
- Accepts read/write commands on a valid/ready channel and buffers them in a small command FIFO.
- Drives single-word bus cycles through if_io.master and returns read data on a response channel.
- Lets a non-CPU agent (host bridge, test sequencer) exercise peripheral slaves such as LEDs, HEX, KEY and SW, using the same address map as the CPU.

Parameters:
- DEPTH, 4, command FIFO depth in entries; power of two, 2..16.
- RD_WAIT, 0, extra cycles rd is held before din is sampled; 0..7.

Ports:
- io.clk  input  1  clock, carried in if_io
- reset  input  1  reset, synchronous, active-high
- cmd_valid  input  1  command present
- cmd_ready  output  1  FIFO has space
- cmd_write  input  1  1 = write, 0 = read
- cmd_addr  input  16  I/O address (ioaddr map)
- cmd_wdata  input  16  write data
- rsp_valid  output  1  read data available
- rsp_ready  input  1  consumer accepts response
- rsp_rdata  output  16  captured io.din
- busy  output  1  FIFO non-empty or bus cycle in progress
- io  if_io.master  -  drives rd, wr, addr, dout; samples din

Behaviour:
- Reset values: io.rd=0, io.wr=0, io.addr=0, io.dout=0, rsp_valid=0, rsp_rdata=0, busy=0, cmd_ready=1. FIFO is emptied and FSM returns to IDLE, including mid-cycle; an aborted read produces no response.
- Command accept: a command is pushed when cmd_valid && cmd_ready. cmd_ready = !full, registered-free (combinational from FIFO count).
- FSM states: IDLE, WRITE, READ, RESP.
- IDLE:
  - If the FIFO is non-empty, pop the head and load io.addr.
  - Write command: io.dout=wdata, io.wr=1 for the next cycle, go to WRITE.
  - Read command: io.rd=1, go to READ with wait counter = RD_WAIT.
- WRITE: exactly one cycle with wr=1. Then wr=0, dout holds its value, and the FSM returns to IDLE. Back-to-back writes therefore issue a strobe every 2 cycles.
- READ:
  - rd held high and addr stable.
  - When the wait counter is 0, rsp_rdata <= io.din, rd <= 0, rsp_valid <= 1, go to RESP.
  - Otherwise decrement the counter.
  - Read latency from pop to rsp_valid is RD_WAIT+2 cycles.
- RESP: wait for rsp_ready. On rsp_valid && rsp_ready, deassert rsp_valid and go to IDLE. rsp_rdata is stable while rsp_valid=1. No new bus cycle is issued while a response is pending, so read order is preserved.
- rd and wr are never asserted together. Both are 0 in IDLE and RESP.
- io.din is an OR-bus; the full 16 bits are captured unmodified.
- Simultaneous push and pop on a full FIFO: push is refused (cmd_ready=0). On an empty FIFO, push-then-pop occurs on consecutive cycles; there is no bypass.
- busy = (FIFO count != 0) || (state != IDLE).

Optional Feature:
- Macro: IO_BUS_MASTER_BURST_EN.
- With the macro defined:
  - Extra input cmd_len (4 bits) is stored per FIFO entry.
  - The command expands to cmd_len+1 bus cycles at addr, addr+1, ….
  - Writes reuse cmd_wdata for every beat.
  - Reads return one response per beat, each handshaked in order.
  - addr wraps 16'hFFFF -> 16'h0000.
  - Reset mid-burst discards the remaining beats.
- Without the macro: the port is absent and every command is a single beat.

Decomposition:
- Package io_bus_master_pkg:
  - state_t enum {IDLE, WRITE, READ, RESP};
  - cmd_t struct {write, addr[15:0], wdata[15:0], len[3:0] (burst only)};
  - constant ADDR_W=16, DATA_W=16.
- Address constants come from the existing ioaddr package.
- Sub-module io_cmd_fifo:
  - Synchronous FIFO of cmd_t with DEPTH entries.
  - Ports push/pop/full/empty/count.
  - Reset clears the pointers.

Test Plan:
- Single write addr=LEDG, wdata=16'h00A5 -> wr=1 for exactly 1 cycle with addr=LEDG, dout=16'h00A5; slave ledg=8'hA5; busy drops 2 cycles after pop.
- Read addr=SW, slave sw=10'h2C3, RD_WAIT=0 -> rd high 1 cycle; rsp_valid 2 cycles after pop with rsp_rdata=16'h02C3.
- Fill FIFO with 4 writes (DEPTH=4) while a read response is stalled (rsp_ready=0) -> cmd_ready=0, 5th command not accepted, no wr strobe until rsp_ready=1; then all 4 writes issue in order.
- RD_WAIT=3, read KEY=4'h9 -> rd held 4 cycles, addr stable, rsp_rdata=16'h0009; rd and wr never overlap.
- Assert reset during READ with FIFO holding 2 commands -> next cycle rd=0, rsp_valid=0, cmd_ready=1, busy=0; no response emitted afterwards.
- BURST_EN: write cmd_len=3, addr=HEX0, wdata=16'h0040 -> 4 wr strobes at HEX0..HEX3, all hex digits show ~7'h40.
